naive_intt: RTL and testbench

//  Naive O(N^2) inverse NTT: y[i] = n_inv * sum_j x[j]*omega_inv^(i*j) mod q.

---
 rtl/naive_intt.sv | 135 +++++++++++++
 tb/tb_naive_intt.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/naive_intt.sv
// Sequential O(N^2) inverse NTT: one modular multiply-accumulate per cycle, single result buffer.
// Define NAIVE_INTT_SCALE_EN to scale each output by n_inv; otherwise the result is N times the inverse.
module naive_intt #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] data_in,
    input  logic [W-1:0]   omega_inv,
    input  logic [W-1:0]   n_inv,
    input  logic [W-1:0]   mod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] data_out,
    output logic           busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * W + 1;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

    state_t        state;
    logic [W-1:0]  x [N];
    logic [W-1:0]  q;
    logic [W-1:0]  omega_r;
    logic [W-1:0]  acc;
    logic [W-1:0]  w;
    logic [W-1:0]  step;
    logic [CW-1:0] i;
    logic [CW-1:0] j;
    logic          accept;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  w_next;
    logic [W-1:0]  step_next;
    logic [W-1:0]  y_val;

    // A modulus below 2 forces every reduced value to zero, which also keeps % away from a zero divisor.
    function automatic logic [W-1:0] reduce(input logic [PW-1:0] a, input logic [W-1:0] m);
        if (m < W'(2)) return '0;
        return W'(a % PW'(m));
    endfunction

    assign accept    = in_valid && in_ready;
    assign acc_next  = reduce(PW'(acc) + PW'(x[j]) * PW'(w), q);
    assign w_next    = reduce(PW'(w) * PW'(step), q);
    assign step_next = reduce(PW'(step) * PW'(omega_r), q);

`ifdef NAIVE_INTT_SCALE_EN
    logic [W-1:0] n_inv_r;

    always_ff @(posedge clk) begin
        if (accept) n_inv_r <= n_inv;
    end

    assign y_val = reduce(PW'(acc) * PW'(n_inv_r), q);
`else
    logic unused_n_inv;

    assign unused_n_inv = ^n_inv;
    assign y_val        = acc;
`endif

    // NOTE: operand storage has no reset; it is only read after an accept has loaded it.
    always_ff @(posedge clk) begin
        if (accept) begin
            q       <= mod;
            omega_r <= omega_inv;
            for (int k = 0; k < N; k++) begin
                x[k] <= reduce(PW'(data_in[k*W +: W]), mod);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
            acc       <= '0;
            w         <= '0;
            step      <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        i        <= '0;
                        j        <= '0;
                        acc      <= '0;
                        w        <= W'(1);
                        step     <= W'(1);
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    w   <= w_next;
                    j   <= j + 1'b1;
                    if (j == CW'(N - 1)) state <= SCALE;
                end
                SCALE: begin
                    data_out[int'(i)*W +: W] <= y_val;
                    step <= step_next;
                    acc  <= '0;
                    w    <= W'(1);
                    j    <= '0;
                    i    <= i + 1'b1;
                    if (i == CW'(N - 1)) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= MAC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_naive_intt.sv
// Scoreboard bench for naive_intt: a direct-formula model pushes expected results at accept,
// popped and compared when out_valid rises. Expectations follow NAIVE_INTT_SCALE_EN.
module tb_naive_intt;
    localparam int N = 8;
    localparam int W = 8;
`ifdef NAIVE_INTT_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif
    localparam logic [63:0] DELTA_Y = SCALED ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h0101_0101_0101_0101;
    localparam logic [63:0] CONST_Y = SCALED ? 64'h0000_0000_0000_0001 : 64'h0000_0000_0000_0008;
    localparam logic [63:0] RT_Y    = SCALED ? 64'h0807_0605_0403_0201 : 64'h0D05_0E06_0F07_1008;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] data_in;
    logic [W-1:0]   omega_inv;
    logic [W-1:0]   n_inv;
    logic [W-1:0]   mod;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] data_out;
    logic           busy;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    logic [63:0] sb [$];

    naive_intt #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .omega_inv(omega_inv), .n_inv(n_inv), .mod(mod),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pw(input int b, input int e, input int m);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = (r * (b % m)) % m;
        return r;
    endfunction

    // y[i] = n_inv * sum_j x[j] * om^(i*j) mod q, evaluated directly with exponentiation.
    function automatic logic [63:0] model(input logic [63:0] d, input int om, input int ni, input int q);
        logic [63:0] r;
        int s;
        r = '0;
        if (q < 2) return r;
        for (int ii = 0; ii < N; ii++) begin
            s = 0;
            for (int jj = 0; jj < N; jj++) begin
                s = (s + (int'(d[jj*W +: W]) % q) * pw(om, ii * jj, q)) % q;
            end
            if (SCALED) s = (s * ni) % q;
            r[ii*W +: W] = 8'(s);
        end
        return r;
    endfunction

    // Forward NTT with omega=2, q=17.
    function automatic logic [63:0] fwd(input logic [63:0] d);
        logic [63:0] r;
        int s;
        r = '0;
        for (int kk = 0; kk < N; kk++) begin
            s = 0;
            for (int jj = 0; jj < N; jj++) s = (s + int'(d[jj*W +: W]) * pw(2, jj * kk, 17)) % 17;
            r[kk*W +: W] = 8'(s);
        end
        return r;
    endfunction

    task automatic send(input logic [63:0] x, input logic [7:0] om, input logic [7:0] ni,
                        input logic [7:0] q, output int acc_cyc);
        data_in   = x;
        omega_inv = om;
        n_inv     = ni;
        mod       = q;
        in_valid  = 1'b1;
        for (int k = 0; k < 300 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (!in_ready) begin
            $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            acc_cyc  = cyc;
        end else begin
            n_pass++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            acc_cyc  = cyc;
            sb.push_back(model(x, int'(om), int'(ni), int'(q)));
            // Scramble the inputs: they must have been sampled only at the accept edge.
            data_in   = {$urandom, $urandom};
            omega_inv = 8'($urandom);
            n_inv     = 8'($urandom);
            mod       = 8'($urandom);
        end
    endtask

    task automatic collect(input string name, input int acc_cyc, output int lat, output logic [63:0] got);
        logic [63:0] want;
        for (int k = 0; k < 300 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        lat = cyc - acc_cyc;
        got = data_out;
        n_checks++;
        if (!out_valid) $display("FAIL %s_out_valid: got %0b required 1", name, out_valid);
        else n_pass++;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s_scoreboard: got empty queue required one entry", name);
        end else begin
            want = sb.pop_front();
            if (got !== want) $display("FAIL %s_data: got %h required %h", name, got, want);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        omega_inv = '0;
        n_inv     = '0;
        mod       = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b required 0", out_valid); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else n_pass++;
        n_checks++;
        if (data_out !== 64'h0) $display("FAIL reset_data_out: got %h required 0", data_out); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_delta();
        int a, lat;
        logic [63:0] got;
        send(64'h1, 8'd9, 8'd15, 8'd17, a);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL delta_busy: busy=%0b in_ready=%0b required 1 0", busy, in_ready);
        else n_pass++;
        collect("delta", a, lat, got);
        n_checks++;
        if (lat != 72) $display("FAIL delta_latency: got %0d required 72", lat); else n_pass++;
        n_checks++;
        if (got !== DELTA_Y) $display("FAIL delta_value: got %h required %h", got, DELTA_Y); else n_pass++;
    endtask

    task automatic test_constant();
        int a, lat;
        logic [63:0] got;
        send(64'h0101_0101_0101_0101, 8'd9, 8'd15, 8'd17, a);
        collect("constant", a, lat, got);
        n_checks++;
        if (got !== CONST_Y) $display("FAIL constant_value: got %h required %h", got, CONST_Y); else n_pass++;
    endtask

    task automatic test_round_trip();
        int a, lat;
        logic [63:0] got;
        send(fwd(64'h0807_0605_0403_0201), 8'd9, 8'd15, 8'd17, a);
        collect("round_trip", a, lat, got);
        n_checks++;
        if (got !== RT_Y) $display("FAIL round_trip_value: got %h required %h", got, RT_Y); else n_pass++;
    endtask

    task automatic test_backpressure();
        int a, lat;
        logic [63:0] snap, got;
        logic bad;
        send({$urandom, $urandom}, 8'd9, 8'd15, 8'd17, a);
        for (int k = 0; k < 300 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        snap = data_out;
        bad  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k == 5);
            @(posedge clk); #1;
            if (data_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad) $display("FAIL backpressure_hold: got unstable or ready output required stable, in_ready=0");
        else n_pass++;
        collect("backpressure", a, lat, got);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_pulse: busy=%0b in_ready=%0b required 0 1", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int a, lat;
        logic [63:0] got;
        send(64'h0807_0605_0403_0201, 8'd9, 8'd15, 8'd17, a);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_mid: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1", out_valid, busy, in_ready);
        else n_pass++;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(64'h1, 8'd9, 8'd15, 8'd17, a);
        collect("reset_mid_delta", a, lat, got);
        n_checks++;
        if (got !== DELTA_Y) $display("FAIL reset_mid_value: got %h required %h", got, DELTA_Y); else n_pass++;
    endtask

    task automatic test_mod_one();
        int a, lat;
        logic [63:0] got;
        send({$urandom, $urandom}, 8'd9, 8'd15, 8'd1, a);
        collect("mod_one", a, lat, got);
        n_checks++;
        if (lat != 72) $display("FAIL mod_one_latency: got %0d required 72", lat); else n_pass++;
        n_checks++;
        if (got !== 64'h0) $display("FAIL mod_one_value: got %h required 0", got); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a, prev, lat;
        logic [63:0] got;
        logic [7:0] q;
        prev = 0;
        for (int t = 0; t < 6; t++) begin
            q = (t == 5) ? 8'd0 : 8'($urandom_range(2, 255));
            send({$urandom, $urandom}, 8'($urandom), 8'($urandom), q, a);
            if (t > 0) begin
                n_checks++;
                if (a - prev != 74) $display("FAIL back_to_back_spacing: got %0d required 74", a - prev);
                else n_pass++;
            end
            prev = a;
            collect("back_to_back", a, lat, got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_delta();
        test_constant();
        test_round_trip();
        test_backpressure();
        test_reset_mid();
        test_mod_one();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
